// File: rtl/button_conditioner.sv
// Synchronises and debounces two push-buttons and a switch bank, producing
// non-overlapping single-cycle press strobes and a switch snapshot taken on each strobe.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned NO_WIDTH        = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn1_raw,
  input  logic                btn2_raw,
  input  logic [NO_WIDTH-1:0] sw_raw,
  output logic                push1,
  output logic                push2,
  output logic [NO_WIDTH-1:0] no
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    StIdle,
    StWaitPress,
    StHeld,
    StWaitRelease
  } state_e;

  logic [1:0]          btn_raw;
  logic [1:0]          btn_sync1_q, btn_sync2_q;
  logic [NO_WIDTH-1:0] sw_sync1_q, sw_sync2_q;
  logic [1:0]          accept;

  assign btn_raw = {btn2_raw, btn1_raw};

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_sync1_q <= '0;
      btn_sync2_q <= '0;
      sw_sync1_q  <= '0;
      sw_sync2_q  <= '0;
    end else begin
      btn_sync1_q <= btn_raw;
      btn_sync2_q <= btn_sync1_q;
      sw_sync1_q  <= sw_raw;
      sw_sync2_q  <= sw_sync1_q;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_btn
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] cnt_inc;
    logic            sync;
    logic            acc;

    assign sync    = btn_sync2_q[b];
    assign cnt_inc = cnt_q + CntW'(1);

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= StIdle;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
        StIdle: begin
          if (sync) begin
            state_d = StWaitPress;
            cnt_d   = CntW'(1);
          end
        end
        StWaitPress: begin
          if (!sync) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (cnt_inc == CntMax) begin
            state_d = StHeld;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        StHeld: begin
          if (!sync) begin
            state_d = StWaitRelease;
            cnt_d   = CntW'(1);
          end
        end
        StWaitRelease: begin
          if (sync) begin
            state_d = StHeld;
            cnt_d   = '0;
          end else if (cnt_inc == CntMax) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end

    // Accept fires on the edge that completes press qualification.
    always_comb begin
      acc = (state_q == StWaitPress) && sync && (cnt_inc == CntMax);
    end

    assign accept[b] = acc;
  end

  logic                push1_q, push2_q, pend2_q;
  logic                push1_d, push2_d, pend2_d;
  logic [NO_WIDTH-1:0] no_q, no_d;

  // Button 1 wins a collision; button 2 is deferred and merges into one pending strobe.
  always_comb begin
    push1_d = accept[0];
    push2_d = !accept[0] && (accept[1] || pend2_q);
    pend2_d = accept[0] && (accept[1] || pend2_q);
    no_d    = (push1_d || push2_d) ? sw_sync2_q : no_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      push1_q <= 1'b0;
      push2_q <= 1'b0;
      pend2_q <= 1'b0;
      no_q    <= '0;
    end else begin
      push1_q <= push1_d;
      push2_q <= push2_d;
      pend2_q <= pend2_d;
      no_q    <= no_d;
    end
  end

  assign push1 = push1_q;
  assign push2 = push2_q;
  assign no    = no_q;

endmodule
